// File: rtl/spi_main_if.sv
// Bus bundle between spi_main and its environment: host handshake plus the SPI pins.
interface spi_main_if #(
  parameter int WIDTH = 128
);
  logic             start;
  logic [WIDTH-1:0] tx_data;
  logic [WIDTH-1:0] rx_data;
  logic             busy;
  logic             done;
  logic             cs;
  logic             sclk;
  logic             sdi;
  logic             sdo;

  modport master (
    input  start, tx_data, sdo,
    output rx_data, busy, done, cs, sclk, sdi
  );

  modport slave (
    output start, tx_data, sdo,
    input  rx_data, busy, done, cs, sclk, sdi
  );
endinterface

// File: rtl/spi_main.sv
// SPI controller for the 128-bit AES subordinate link: MSB-first full-duplex transfer,
// sclk divided from clk, plus one cs-high flush pulse after reset and after every transfer.
// state    | meaning
// INIT_HI/LO  | post-reset flush pulse, busy held high
// IDLE        | waiting for start
// SETUP       | cs low, first data bit on sdi
// HIGH/LOW    | sclk high/low half of each bit
// HOLD        | cs high, sdi low before flush
// FLUSH_HI/LO | flush pulse; done raised on its final edge
module spi_main #(
  parameter int WIDTH   = 128,
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_main_if.master bus
);

  localparam int HC_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [3:0] {
    INIT_HI,
    INIT_LO,
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    FLUSH_HI,
    FLUSH_LO
  } state_t;

  state_t             state, state_n;
  logic [HC_W-1:0]    hc, hc_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [WIDTH-2:0]   tx_sr, tx_sr_n;
  logic [WIDTH-1:0]   rx_sr, rx_sr_n;
  logic [WIDTH-1:0]   rx_q, rx_q_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic               cs_q, cs_n;
  logic               sclk_q, sclk_n;
  logic               sdi_q, sdi_n;
  logic               hc_last;

  assign hc_last = (hc == HC_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= INIT_HI;
      hc     <= '0;
      cnt    <= '0;
      tx_sr  <= '0;
      rx_sr  <= '0;
      rx_q   <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
      cs_q   <= 1'b1;
      sclk_q <= 1'b0;
      sdi_q  <= 1'b0;
    end else begin
      state  <= state_n;
      hc     <= hc_n;
      cnt    <= cnt_n;
      tx_sr  <= tx_sr_n;
      rx_sr  <= rx_sr_n;
      rx_q   <= rx_q_n;
      busy_q <= busy_n;
      done_q <= done_n;
      cs_q   <= cs_n;
      sclk_q <= sclk_n;
      sdi_q  <= sdi_n;
    end
  end

  always_comb begin
    state_n = state;
    hc_n    = hc_last ? '0 : hc + HC_W'(1);
    cnt_n   = cnt;
    tx_sr_n = tx_sr;
    rx_sr_n = rx_sr;
    rx_q_n  = rx_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    cs_n    = cs_q;
    sclk_n  = sclk_q;
    sdi_n   = sdi_q;

    case (state)
      INIT_HI: begin
        sclk_n = 1'b1;
        if (hc_last) state_n = INIT_LO;
      end
      INIT_LO: begin
        sclk_n = 1'b0;
        if (hc_last) begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      IDLE: begin
        hc_n   = '0;
        busy_n = 1'b0;
        if (bus.start) begin
          // MSB goes straight to sdi, so the shifter only keeps the remaining bits
          tx_sr_n = bus.tx_data[WIDTH-2:0];
          sdi_n   = bus.tx_data[WIDTH-1];
          cs_n    = 1'b0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (hc_last) begin
          sclk_n  = 1'b1;
          state_n = HIGH;
        end
      end
      HIGH: begin
        if (hc_last) begin
          sclk_n  = 1'b0;
          rx_sr_n = {rx_sr[WIDTH-2:0], bus.sdo};
          cnt_n   = cnt + CNT_W'(1);
          state_n = LOW;
        end
      end
      LOW: begin
        if (hc_last) begin
          if (cnt < CNT_W'(WIDTH)) begin
            sclk_n  = 1'b1;
            sdi_n   = tx_sr[WIDTH-2];
            tx_sr_n = {tx_sr[WIDTH-3:0], 1'b0};
            state_n = HIGH;
          end else begin
            cs_n    = 1'b1;
            sdi_n   = 1'b0;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (hc_last) begin
          sclk_n  = 1'b1;
          state_n = FLUSH_HI;
        end
      end
      FLUSH_HI: begin
        if (hc_last) begin
          sclk_n  = 1'b0;
          state_n = FLUSH_LO;
        end
      end
      FLUSH_LO: begin
        if (hc_last) begin
          rx_q_n  = rx_sr;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = INIT_HI;
    endcase
  end

  assign bus.rx_data = rx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cs      = cs_q;
  assign bus.sclk    = sclk_q;
  assign bus.sdi     = sdi_q;

endmodule

// File: tb/tb_spi_main.sv
// Directed-plus-random bench for spi_main: one instance at CLK_DIV=2, one at CLK_DIV=1,
// a behavioural SPI subordinate and a word-level reference of what each side must receive.
module tb_spi_main;
  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sel = 1'b0;
  logic         loop = 1'b1;
  logic         start_drv = 1'b0;
  logic [W-1:0] tx_drv = '0;
  logic         slv_sdo = 1'b0;
  logic [W-1:0] slv_tx = '0;
  logic [W-1:0] slv_rx = '0;
  int           slv_cnt = 0;
  int           vectors = 0;
  int           miscompares = 0;

  always #5 clk = ~clk;

  spi_main_if #(.WIDTH(W)) if0 ();
  spi_main_if #(.WIDTH(W)) if1 ();

  spi_main #(.WIDTH(W), .CLK_DIV(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  spi_main #(.WIDTH(W), .CLK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  assign if0.start   = start_drv & ~sel;
  assign if1.start   = start_drv & sel;
  assign if0.tx_data = tx_drv;
  assign if1.tx_data = tx_drv;
  assign if0.sdo     = loop ? if0.sdi : slv_sdo;
  assign if1.sdo     = loop ? if1.sdi : slv_sdo;

  wire         c_busy = sel ? if1.busy : if0.busy;
  wire         c_done = sel ? if1.done : if0.done;
  wire         c_cs   = sel ? if1.cs   : if0.cs;
  wire         c_sclk = sel ? if1.sclk : if0.sclk;
  wire         c_sdi  = sel ? if1.sdi  : if0.sdi;
  wire [W-1:0] c_rx   = sel ? if1.rx_data : if0.rx_data;

  // Subordinate: launches on rising sclk, captures on falling sclk; a cs-high pulse clears it.
  always @(posedge c_sclk) begin
    if (c_cs) slv_cnt = 0;
    else if (slv_cnt < W) slv_sdo = slv_tx[W-1-slv_cnt];
  end

  always @(negedge c_sclk) begin
    if (!c_cs) begin
      slv_rx  = {slv_rx[W-2:0], c_sdi};
      slv_cnt = slv_cnt + 1;
    end
  end

  function automatic logic [W-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer on the selected instance and reports edge numbers relative to acceptance.
  task automatic xfer(input logic [W-1:0] word, input int rej_edge, input int tail,
                      output int t_done, output int t_fall1, output int t_csr, output int n_done);
    int   limit;
    logic ps, pc;
    limit   = (2 * W + 4) * (sel ? 1 : 2) + 40;
    t_done  = -1;
    t_fall1 = -1;
    t_csr   = -1;
    n_done  = 0;
    @(negedge clk);
    tx_drv    = word;
    start_drv = 1'b1;
    @(posedge clk);
    #1;
    start_drv = 1'b0;
    tx_drv    = rnd_word();
    ps = c_sclk;
    pc = c_cs;
    for (int e = 1; e <= limit; e++) begin
      if (e == rej_edge) begin
        start_drv = 1'b1;
        tx_drv    = ~word;
      end
      @(posedge clk);
      #1;
      start_drv = 1'b0;
      if (ps && !c_sclk && t_fall1 < 0) t_fall1 = e;
      if (!pc && c_cs && t_csr < 0) t_csr = e;
      if (c_done) begin
        n_done++;
        if (t_done < 0) t_done = e;
      end
      ps = c_sclk;
      pc = c_cs;
      if (t_done >= 0 && e >= t_done + tail) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] word;
    logic [W-1:0] sword;
    int td, tf, tc, nd;
    int h;

    // Reset values while rst_n is held low
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", if0.busy, 1);
    check("rst_cs", if0.cs, 1);
    check("rst_sclk", if0.sclk, 0);
    check("rst_sdi", if0.sdi, 0);
    check("rst_done", if0.done, 0);
    check("rst_rx", if0.rx_data, 0);
    check("rst_busy_div1", if1.busy, 1);

    // Init flush: busy high until edge 2H, sclk high on edges 1..H, cs high, no done
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("init_busy_e%0d", e), if0.busy, (e < 4) ? 1 : 0);
      check($sformatf("init_sclk_e%0d", e), if0.sclk, (e <= 2) ? 1 : 0);
      check($sformatf("init_cs_e%0d", e), if0.cs, 1);
      check($sformatf("init_done_e%0d", e), if0.done, 0);
      if (e <= 2) begin
        check($sformatf("init1_busy_e%0d", e), if1.busy, (e < 2) ? 1 : 0);
        check($sformatf("init1_sclk_e%0d", e), if1.sclk, (e <= 1) ? 1 : 0);
      end
    end
    check("init_rx", if0.rx_data, 0);

    // Loopback with the fixed word and with random words
    sel  = 1'b0;
    loop = 1'b1;
    h    = 2;
    word = 128'h0123456789ABCDEF_FEDCBA9876543210;
    xfer(word, -1, 4, td, tf, tc, nd);
    check("loop_rx", c_rx, word);
    check("loop_done_edge", td, (2 * W + 4) * h);
    check("loop_first_fall", tf, 2 * h);
    check("loop_cs_rise", tc, (2 * W + 1) * h);
    check("loop_done_count", nd, 1);
    for (int i = 0; i < 2; i++) begin
      word = rnd_word();
      xfer(word, -1, 2, td, tf, tc, nd);
      check($sformatf("loop_rand%0d_rx", i), c_rx, word);
      check($sformatf("loop_rand%0d_done", i), td, (2 * W + 4) * h);
    end

    // Subordinate exchange, repeated back to back
    loop   = 1'b0;
    word   = {16{8'hA5}};
    slv_tx = {16{8'h3C}};
    for (int i = 0; i < 2; i++) begin
      check($sformatf("pair%0d_slv_cnt_before", i), slv_cnt, 0);
      xfer(word, -1, 0, td, tf, tc, nd);
      check($sformatf("pair%0d_rx", i), c_rx, slv_tx);
      check($sformatf("pair%0d_slv_rx", i), slv_rx, word);
      check($sformatf("pair%0d_done", i), td, (2 * W + 4) * h);
    end
    check("pair_slv_cnt_after", slv_cnt, 0);
    word   = rnd_word();
    slv_tx = rnd_word();
    xfer(word, -1, 2, td, tf, tc, nd);
    check("pair_rand_rx", c_rx, slv_tx);
    check("pair_rand_slv_rx", slv_rx, word);

    // start with different data while busy must be ignored
    loop = 1'b1;
    word = rnd_word();
    xfer(word, 100, 20, td, tf, tc, nd);
    check("rej_rx", c_rx, word);
    check("rej_done_count", nd, 1);
    check("rej_done_edge", td, (2 * W + 4) * h);

    // Reset mid-transfer while sclk is high during bit 61
    loop   = 1'b0;
    slv_tx = rnd_word();
    @(negedge clk);
    tx_drv    = rnd_word();
    start_drv = 1'b1;
    @(posedge clk);
    #1;
    start_drv = 1'b0;
    repeat (243) @(posedge clk);
    #3;
    check("mid_sclk_before", c_sclk, 1);
    check("mid_cs_before", c_cs, 0);
    rst_n = 1'b0;
    #1;
    check("mid_cs_async", c_cs, 1);
    check("mid_sclk_async", c_sclk, 0);
    check("mid_rx_async", c_rx, 0);
    check("mid_busy_async", c_busy, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20 && c_busy; i++) begin
      @(posedge clk);
      #1;
    end
    check("mid_busy_released", c_busy, 0);
    word   = rnd_word();
    slv_tx = rnd_word();
    xfer(word, -1, 2, td, tf, tc, nd);
    check("mid_after_rx", c_rx, slv_tx);
    check("mid_after_slv_rx", slv_rx, word);
    check("mid_after_done", td, (2 * W + 4) * h);

    // CLK_DIV=1 instance: all ones in loopback, all zeros against the subordinate
    sel  = 1'b1;
    h    = 1;
    loop = 1'b1;
    word = '1;
    xfer(word, -1, 2, td, tf, tc, nd);
    check("div1_ones_rx", c_rx, word);
    check("div1_ones_done", td, (2 * W + 4) * h);
    check("div1_first_fall", tf, 2 * h);
    check("div1_cs_rise", tc, (2 * W + 1) * h);
    loop   = 1'b0;
    word   = '0;
    slv_tx = rnd_word();
    xfer(word, -1, 2, td, tf, tc, nd);
    check("div1_zeros_rx", c_rx, slv_tx);
    check("div1_zeros_slv_rx", slv_rx, word);
    check("div1_zeros_done", td, (2 * W + 4) * h);
    check("div1_done_count", nd, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
